// File: rtl/spi_ram_cmd.sv
// spi_ram_cmd: command-decoding single-port RAM downstream of an SPI slave.
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   din[9:0]  in   slave frame: [9:8] command, [7:0] payload
//   rx_valid  in   frame valid; only its rising edge accepts a command
//   dout[7:0] out  read data towards the slave tx_data
//   tx_valid  out  dout valid; held until the next accepted command
//   seq_err   out  one-cycle pulse on sequencing or range violation
//
// Commands: 00 write-address, 01 write-data, 10 read-address, 11 read-data.
module spi_ram_cmd #(
  parameter int unsigned MEM_DEPTH = 256,
  parameter int unsigned ADDR_SIZE = 8,
  parameter bit          AUTO_INC  = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] din,
  input  logic       rx_valid,
  output logic [7:0] dout,
  output logic       tx_valid,
  output logic       seq_err
);

  localparam int unsigned IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_SIZE:0]   DEPTH_EXT = (ADDR_SIZE + 1)'(MEM_DEPTH);
  localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(MEM_DEPTH - 1);

  typedef enum logic [1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } cmd_e;

  logic [7:0] mem [MEM_DEPTH];

  logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_SIZE-1:0] rd_addr_q, rd_addr_d;
  logic                 wr_armed_q, wr_armed_d;
  logic                 rd_armed_q, rd_armed_d;
  logic                 rx_valid_q, rx_valid_d;
  logic [7:0]           dout_q, dout_d;
  logic                 tx_valid_q, tx_valid_d;
  logic                 seq_err_q, seq_err_d;

  logic                 accept;
  logic                 mem_we;
  cmd_e                 cmd;
  logic [ADDR_SIZE-1:0] cmd_addr;
  logic                 cmd_addr_ok;
  logic                 wr_addr_ok;
  logic                 rd_addr_ok;
  logic [ADDR_SIZE-1:0] wr_addr_inc;
  logic [ADDR_SIZE-1:0] rd_addr_inc;

  assign cmd         = cmd_e'(din[9:8]);
  assign cmd_addr    = din[ADDR_SIZE-1:0];
  // Zero-extend by one bit so MEM_DEPTH == 2**ADDR_SIZE still compares correctly.
  assign cmd_addr_ok = {1'b0, cmd_addr}  < DEPTH_EXT;
  assign wr_addr_ok  = {1'b0, wr_addr_q} < DEPTH_EXT;
  assign rd_addr_ok  = {1'b0, rd_addr_q} < DEPTH_EXT;
  assign wr_addr_inc = (wr_addr_q == LAST_ADDR) ? '0 : wr_addr_q + 1'b1;
  assign rd_addr_inc = (rd_addr_q == LAST_ADDR) ? '0 : rd_addr_q + 1'b1;

  // rx_valid_q resets high, so a frame valid already asserted at reset
  // release is ignored until it drops.
  assign accept = rx_valid & ~rx_valid_q;

  always_comb begin
    wr_addr_d  = wr_addr_q;
    rd_addr_d  = rd_addr_q;
    wr_armed_d = wr_armed_q;
    rd_armed_d = rd_armed_q;
    rx_valid_d = rx_valid;
    dout_d     = dout_q;
    tx_valid_d = tx_valid_q;
    seq_err_d  = 1'b0;
    mem_we     = 1'b0;

    if (accept) begin
      tx_valid_d = 1'b0;
      unique case (cmd)
        CMD_WR_ADDR: begin
          wr_addr_d = cmd_addr;
          if (cmd_addr_ok) begin
            wr_armed_d = 1'b1;
          end else begin
            seq_err_d = 1'b1;
          end
        end
        CMD_WR_DATA: begin
          mem_we    = wr_addr_ok;
          seq_err_d = ~wr_armed_q | ~wr_addr_ok;
          if (AUTO_INC) begin
            wr_addr_d = wr_addr_inc;
          end
        end
        CMD_RD_ADDR: begin
          rd_addr_d = cmd_addr;
          if (cmd_addr_ok) begin
            rd_armed_d = 1'b1;
          end else begin
            seq_err_d = 1'b1;
          end
        end
        CMD_RD_DATA: begin
          dout_d     = rd_addr_ok ? mem[rd_addr_q[IDX_W-1:0]] : '0;
          tx_valid_d = 1'b1;
          seq_err_d  = ~rd_armed_q | ~rd_addr_ok;
          if (AUTO_INC) begin
            rd_addr_d = rd_addr_inc;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      wr_armed_q <= 1'b0;
      rd_armed_q <= 1'b0;
      rx_valid_q <= 1'b1;
      dout_q     <= '0;
      tx_valid_q <= 1'b0;
      seq_err_q  <= 1'b0;
    end else begin
      wr_addr_q  <= wr_addr_d;
      rd_addr_q  <= rd_addr_d;
      wr_armed_q <= wr_armed_d;
      rd_armed_q <= rd_armed_d;
      rx_valid_q <= rx_valid_d;
      dout_q     <= dout_d;
      tx_valid_q <= tx_valid_d;
      seq_err_q  <= seq_err_d;
    end
  end

  // Storage is deliberately outside the reset domain: contents survive rst_n.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_addr_q[IDX_W-1:0]] <= din[7:0];
    end
  end

  assign dout     = dout_q;
  assign tx_valid = tx_valid_q;
  assign seq_err  = seq_err_q;

endmodule

// File: tb/tb_spi_ram_cmd.sv
// tb_spi_ram_cmd: randomized self-checking bench for spi_ram_cmd.
// Three instances share the stimulus: depth 256 plain, depth 256 with
// auto-increment, depth 128 with auto-increment.
module tb_spi_ram_cmd;

  localparam int NCFG = 3;

  logic       clk;
  logic       rst_n;
  logic [9:0] din;
  logic       rx_valid;
  logic [7:0] dout_w     [NCFG];
  logic       tx_valid_w [NCFG];
  logic       seq_err_w  [NCFG];

  int unsigned n_vec;
  int unsigned n_err;

  // Reference model state, one set per configuration.
  int unsigned cfg_depth [NCFG] = '{256, 256, 128};
  bit          cfg_inc   [NCFG] = '{1'b0, 1'b1, 1'b1};
  logic [7:0]  m_mem   [NCFG][256];
  bit          m_known [NCFG][256];
  int unsigned m_wr    [NCFG];
  int unsigned m_rd    [NCFG];
  bit          m_wa    [NCFG];
  bit          m_ra    [NCFG];
  bit          m_rxq   [NCFG];
  bit          m_tx    [NCFG];
  bit          m_err   [NCFG];
  logic [7:0]  m_dout  [NCFG];
  bit          m_dknown[NCFG];

  spi_ram_cmd #(.MEM_DEPTH(256), .ADDR_SIZE(8), .AUTO_INC(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rx_valid),
    .dout(dout_w[0]), .tx_valid(tx_valid_w[0]), .seq_err(seq_err_w[0])
  );

  spi_ram_cmd #(.MEM_DEPTH(256), .ADDR_SIZE(8), .AUTO_INC(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rx_valid),
    .dout(dout_w[1]), .tx_valid(tx_valid_w[1]), .seq_err(seq_err_w[1])
  );

  spi_ram_cmd #(.MEM_DEPTH(128), .ADDR_SIZE(8), .AUTO_INC(1'b1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rx_valid),
    .dout(dout_w[2]), .tx_valid(tx_valid_w[2]), .seq_err(seq_err_w[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  function automatic int unsigned next_addr(input int unsigned a, input int unsigned depth);
    return (a == depth - 1) ? 0 : (a + 1) % 256;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NCFG; k++) begin
      m_wr[k] = 0;  m_rd[k] = 0;
      m_wa[k] = 0;  m_ra[k] = 0;
      m_rxq[k] = 1; m_tx[k] = 0; m_err[k] = 0;
      m_dout[k] = 8'h00; m_dknown[k] = 1;
    end
  endtask

  task automatic model_step(input logic [9:0] f, input bit v);
    int unsigned a;
    int unsigned d;
    bit acc;
    for (int k = 0; k < NCFG; k++) begin
      d = cfg_depth[k];
      a = int'(f[7:0]);
      acc = v && !m_rxq[k];
      m_rxq[k] = v;
      m_err[k] = 0;
      if (acc) begin
        m_tx[k] = 0;
        m_dknown[k] = 0;
        case (f[9:8])
          2'd0: begin
            m_wr[k] = a;
            if (a < d) m_wa[k] = 1; else m_err[k] = 1;
          end
          2'd1: begin
            if (!m_wa[k]) m_err[k] = 1;
            if (m_wr[k] < d) begin
              m_mem[k][m_wr[k]] = f[7:0];
              m_known[k][m_wr[k]] = 1;
            end else begin
              m_err[k] = 1;
            end
            if (cfg_inc[k]) m_wr[k] = next_addr(m_wr[k], d);
          end
          2'd2: begin
            m_rd[k] = a;
            if (a < d) m_ra[k] = 1; else m_err[k] = 1;
          end
          default: begin
            if (!m_ra[k]) m_err[k] = 1;
            m_tx[k] = 1;
            if (m_rd[k] < d) begin
              m_dout[k] = m_mem[k][m_rd[k]];
              m_dknown[k] = m_known[k][m_rd[k]];
            end else begin
              m_err[k] = 1;
              m_dout[k] = 8'h00;
              m_dknown[k] = 1;
            end
            if (cfg_inc[k]) m_rd[k] = next_addr(m_rd[k], d);
          end
        endcase
      end
    end
  endtask

  task automatic compare_all(input string phase);
    for (int k = 0; k < NCFG; k++) begin
      check_eq($sformatf("%s.tx_valid[%0d]", phase, k), 32'(tx_valid_w[k]), 32'(m_tx[k]));
      check_eq($sformatf("%s.seq_err[%0d]", phase, k), 32'(seq_err_w[k]), 32'(m_err[k]));
      if (m_dknown[k])
        check_eq($sformatf("%s.dout[%0d]", phase, k), 32'(dout_w[k]), 32'(m_dout[k]));
    end
  endtask

  // Inputs are changed at the falling edge; the model advances on the rising
  // edge and the DUT is compared on the following falling edge.
  task automatic tick(input string phase);
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_step(din, rx_valid);
    @(negedge clk);
    compare_all(phase);
  endtask

  task automatic send_cmd(input string phase, input logic [1:0] c, input logic [7:0] p,
                          input int unsigned hold, input int unsigned gap);
    din = {c, p};
    rx_valid = 1'b1;
    repeat (hold) tick(phase);
    rx_valid = 1'b0;
    repeat (gap) tick(phase);
  endtask

  task automatic do_reset(input string phase, input bit rxv_during);
    rst_n = 1'b0;
    rx_valid = rxv_during;
    repeat (2) tick(phase);
    rst_n = 1'b1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    for (int k = 0; k < NCFG; k++)
      for (int a = 0; a < 256; a++) m_known[k][a] = 0;
    din = '0;
    rx_valid = 1'b0;
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    compare_all("reset");
    repeat (2) tick("reset");
    rst_n = 1'b1;
    tick("idle");

    // Held rx_valid: exactly one write-address accept, then confirm address.
    send_cmd("hold", 2'd0, 8'h2A, 12, 1);
    send_cmd("hold", 2'd1, 8'h77, 1, 1);
    send_cmd("hold", 2'd2, 8'h2A, 1, 1);
    send_cmd("hold", 2'd3, 8'h00, 1, 1);

    // Basic write/read with tx_valid held through idle cycles.
    send_cmd("basic", 2'd0, 8'h10, 2, 1);
    send_cmd("basic", 2'd1, 8'hA5, 1, 2);
    send_cmd("basic", 2'd2, 8'h10, 1, 1);
    send_cmd("basic", 2'd3, 8'h00, 3, 5);
    send_cmd("basic", 2'd3, 8'h00, 1, 2);

    // Auto-increment wrap at the top of the 256-word array.
    send_cmd("wrap", 2'd0, 8'hFF, 1, 1);
    send_cmd("wrap", 2'd1, 8'h11, 1, 1);
    send_cmd("wrap", 2'd1, 8'h22, 1, 1);
    send_cmd("wrap", 2'd1, 8'h33, 1, 1);
    send_cmd("wrap", 2'd2, 8'hFF, 1, 1);
    for (int i = 0; i < 3; i++) send_cmd("wrap", 2'd3, 8'h00, 1, 1);

    // Wrap at 127 for the 128-word instance.
    send_cmd("wrap128", 2'd0, 8'h7F, 1, 1);
    send_cmd("wrap128", 2'd1, 8'h6B, 1, 1);
    send_cmd("wrap128", 2'd1, 8'h6C, 1, 1);
    send_cmd("wrap128", 2'd2, 8'h7F, 1, 1);
    send_cmd("wrap128", 2'd3, 8'h00, 1, 1);
    send_cmd("wrap128", 2'd3, 8'h00, 1, 1);

    // Read-data without read-address after reset; rx_valid high across release.
    send_cmd("unarmed", 2'd0, 8'h00, 1, 1);
    send_cmd("unarmed", 2'd1, 8'h5C, 1, 1);
    din = {2'd3, 8'h00};
    do_reset("unarmed", 1'b1);
    repeat (3) tick("unarmed");
    rx_valid = 1'b0;
    tick("unarmed");
    send_cmd("unarmed", 2'd3, 8'h00, 1, 3);

    // Out-of-range address for the 128-word instance.
    send_cmd("range", 2'd0, 8'h90, 1, 1);
    send_cmd("range", 2'd1, 8'h55, 1, 1);
    send_cmd("range", 2'd2, 8'h10, 1, 1);
    send_cmd("range", 2'd3, 8'h00, 1, 1);
    send_cmd("range", 2'd2, 8'h90, 1, 1);
    send_cmd("range", 2'd3, 8'h00, 1, 1);

    // Asynchronous reset while tx_valid is high.
    send_cmd("async", 2'd2, 8'h10, 1, 1);
    send_cmd("async", 2'd3, 8'h00, 1, 1);
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < NCFG; k++) begin
      check_eq($sformatf("async_rst.tx_valid[%0d]", k), 32'(tx_valid_w[k]), 32'd0);
      check_eq($sformatf("async_rst.dout[%0d]", k), 32'(dout_w[k]), 32'd0);
      check_eq($sformatf("async_rst.seq_err[%0d]", k), 32'(seq_err_w[k]), 32'd0);
    end
    model_reset();
    @(negedge clk);
    do_reset("async", 1'b0);
    tick("async");
    send_cmd("async", 2'd2, 8'h10, 1, 1);
    send_cmd("async", 2'd3, 8'h00, 1, 2);

    // Randomized traffic, addresses biased low so reads often hit written words.
    for (int i = 0; i < 400; i++) begin
      logic [1:0] c;
      logic [7:0] p;
      c = 2'($urandom_range(0, 3));
      if (c == 2'd1 || c == 2'd3) p = 8'($urandom_range(0, 255));
      else if ($urandom_range(0, 4) == 0) p = 8'($urandom_range(0, 255));
      else p = 8'($urandom_range(0, 15));
      send_cmd("rand", c, p, $urandom_range(1, 4), $urandom_range(1, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spi_ram_cmd.md
Name: spi_ram_cmd

Overview:
- Command-decoding single-port RAM that sits directly downstream of the SPI slave.
- Consumes the slave's 10-bit frames (rx_data/rx_valid). Bits [9:8] select write-address, write-data, read-address or read-data.
- Returns read data to the slave on dout/tx_valid for shifting onto MISO.
- Adds edge-qualified command acceptance, optional address auto-increment, and a sequencing-error pulse.

Parameters:
- MEM_DEPTH, 256, number of 8-bit words (2..256).
- ADDR_SIZE, 8, address register width; address field is din[ADDR_SIZE-1:0].
- AUTO_INC, 0, 1 = post-increment the relevant address after each write-data/read-data command.

Ports:
- clk  input  1  single clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- din  input  10  frame from SPI slave; [9:8] command, [7:0] payload.
- rx_valid  input  1  frame-valid from SPI slave (may stay high for many cycles).
- dout  output  8  read data to SPI slave tx_data.
- tx_valid  output  1  dout valid, to SPI slave tx_valid.
- seq_err  output  1  one-cycle pulse on a protocol/range violation.

Behaviour:
- Reset (async, rst_n=0): dout=0, tx_valid=0, seq_err=0, wr_addr=0, rd_addr=0, wr_armed=0, rd_armed=0, rx_valid_q=1.
  - Memory array is not reset; contents survive reset.
- Acceptance:
  - accept = rx_valid & ~rx_valid_q; rx_valid_q <= rx_valid every cycle.
  - Exactly one command per rx_valid rising edge; a held-high rx_valid never re-triggers.
  - rx_valid_q resets to 1, so an rx_valid already high at reset release is ignored until it drops.
  - Effects of an accepted command are visible after the accepting clock edge (1-cycle latency).
- Commands on accept, with A = din[ADDR_SIZE-1:0]:
  - 00 write-address: wr_addr<=A; wr_armed<=1.
  - 01 write-data: mem[wr_addr]<=din[7:0].
    - If AUTO_INC: wr_addr<=(wr_addr==MEM_DEPTH-1)?0:wr_addr+1; otherwise wr_addr holds.
  - 10 read-address: rd_addr<=A; rd_armed<=1.
  - 11 read-data: dout<=mem[rd_addr]; tx_valid<=1.
    - If AUTO_INC: rd_addr wraps/increments the same way as wr_addr.
- tx_valid:
  - Set on the read-data accept edge; held high with dout stable until the next accepted command of any type.
  - Cleared on that edge; if that command is itself read-data, tx_valid stays 1 and dout updates.
  - Required because the slave samples tx_data across 8 shift cycles.
- Range: a write-data with wr_addr>=MEM_DEPTH, or a read-address/write-address with A>=MEM_DEPTH:
  - Memory is not written.
  - The address still loads, but the armed flag is not set.
  - A read-data with rd_addr>=MEM_DEPTH returns dout=0 with tx_valid=1.
- seq_err pulses 1 cycle after an accept if any of:
  - write-data with wr_armed=0;
  - read-data with rd_armed=0;
  - any out-of-range address condition above.
  - The command still executes as specified; seq_err never blocks it.
- No state machine beyond the armed flags. Wrap-around of the auto-increment does not clear the armed flags.
- Reset mid-operation: outputs clear immediately (asynchronously); a frame in flight is lost; memory retained.

Test Plan:
- Reset then din=10'h0_2A with rx_valid held high 12 cycles -> one accept only: wr_addr=0x2A, wr_armed=1, seq_err=0.
- 00/0x10 then 01/0xA5, then 10/0x10 then 11/xx -> one cycle after the read-data accept: dout=0xA5, tx_valid=1; both held until the next accept.
- AUTO_INC=1, MEM_DEPTH=256: write-address 0xFF, write-data 0x11, write-data 0x22 -> mem[0xFF]=0x11, mem[0x00]=0x22, wr_addr=0x01.
- After reset, read-data with no prior read-address -> dout=mem[0], tx_valid=1, seq_err single-cycle pulse.
- MEM_DEPTH=128: write-address 0x90, then write-data 0x55 -> no memory write; seq_err pulses twice (once per command); mem[0x10] unchanged.
- Assert rst_n=0 mid-cycle while tx_valid=1 -> tx_valid, dout and seq_err drop to 0 before the next clk edge; after release, read-address 0x10 then read-data -> previously written 0xA5 is returned.
